// File: rtl/control_unit_fsm_pkg.sv
// control_unit_fsm_pkg: opcode, state, ALU and PC-select codes shared by the controller, datapath and bench.
package control_unit_fsm_pkg;

  localparam int CU_OPW = 6;
  localparam int CU_STW = 3;

  typedef enum logic [CU_STW-1:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_L   = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [CU_OPW-1:0] OP_ADD   = 6'b000000;
  localparam logic [CU_OPW-1:0] OP_SUB   = 6'b000001;
  localparam logic [CU_OPW-1:0] OP_ADDIU = 6'b000010;
  localparam logic [CU_OPW-1:0] OP_AND   = 6'b010000;
  localparam logic [CU_OPW-1:0] OP_ANDI  = 6'b010001;
  localparam logic [CU_OPW-1:0] OP_ORI   = 6'b010010;
  localparam logic [CU_OPW-1:0] OP_SLL   = 6'b011000;
  localparam logic [CU_OPW-1:0] OP_SLT   = 6'b100110;
  localparam logic [CU_OPW-1:0] OP_SW    = 6'b110000;
  localparam logic [CU_OPW-1:0] OP_LW    = 6'b110001;
  localparam logic [CU_OPW-1:0] OP_BEQ   = 6'b110100;
  localparam logic [CU_OPW-1:0] OP_BNE   = 6'b110101;
  localparam logic [CU_OPW-1:0] OP_BLTZ  = 6'b110110;
  localparam logic [CU_OPW-1:0] OP_J     = 6'b111000;
  localparam logic [CU_OPW-1:0] OP_JR    = 6'b111001;
  localparam logic [CU_OPW-1:0] OP_JAL   = 6'b111010;
  localparam logic [CU_OPW-1:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JR   = 2'b10;
  localparam logic [1:0] PC_J    = 2'b11;

  localparam logic [1:0] REG_RA = 2'b00;
  localparam logic [1:0] REG_RT = 2'b01;
  localparam logic [1:0] REG_RD = 2'b10;

  typedef enum logic [2:0] {C_HALT, C_ALU, C_LS, C_BR, C_JMP} op_class_t;

  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       ins_mem_rw;
    logic       m_rd;
    logic       m_wr;
    logic       reg_wre;
    logic [1:0] reg_dst;
    logic       wr_reg_d_src;
    logic       db_data_src;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       ext_sel;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic op_class_t classify(logic [CU_OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_SLL, OP_SLT: return C_ALU;
      OP_SW, OP_LW:                                                     return C_LS;
      OP_BEQ, OP_BNE, OP_BLTZ:                                          return C_BR;
      OP_J, OP_JR, OP_JAL:                                              return C_JMP;
      default:                                                          return C_HALT;
    endcase
  endfunction

  // Unknown opcodes classify as halt, so they park in S_ID just like halt.
  function automatic state_t next_state(state_t s, logic [CU_OPW-1:0] op);
    op_class_t c;
    c = classify(op);
    case (s)
      S_IF:     return S_ID;
      S_ID:     return c == C_ALU ? S_EXE_AL : c == C_LS ? S_EXE_LS : c == C_BR ? S_EXE_BR :
                       c == C_JMP ? S_IF : S_ID;
      S_EXE_AL: return S_WB_AL;
      S_EXE_LS: return S_MEM;
      S_MEM:    return op == OP_LW ? S_WB_L : S_IF;
      default:  return S_IF;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_fsm_decoder.sv
// control_unit_fsm_decoder: combinational state+opcode+flags to datapath controls, forced quiet during reset.
module control_unit_fsm_decoder
  import control_unit_fsm_pkg::*;
(
  input  logic              rst_n,
  input  state_t            state,
  input  logic [CU_OPW-1:0] op_code,
  input  logic              zero,
  input  logic              sign,
  output ctrl_t             ctrl
);

  ctrl_t sel;

  always_comb begin
    sel = '0;
    case (op_code)
      OP_ADD:   {sel.reg_dst, sel.wr_reg_d_src} = {REG_RD, 1'b1};
      OP_SUB:   {sel.reg_dst, sel.wr_reg_d_src, sel.alu_op} = {REG_RD, 1'b1, ALU_SUB};
      OP_ADDIU: {sel.reg_dst, sel.wr_reg_d_src, sel.alu_src_b, sel.ext_sel} = {REG_RT, 3'b111};
      OP_AND:   {sel.reg_dst, sel.wr_reg_d_src, sel.alu_op} = {REG_RD, 1'b1, ALU_AND};
      OP_ANDI:  {sel.reg_dst, sel.wr_reg_d_src, sel.alu_src_b, sel.alu_op} = {REG_RT, 2'b11, ALU_AND};
      OP_ORI:   {sel.reg_dst, sel.wr_reg_d_src, sel.alu_src_b, sel.alu_op} = {REG_RT, 2'b11, ALU_OR};
      OP_SLL:   {sel.reg_dst, sel.wr_reg_d_src, sel.alu_src_a, sel.alu_op} = {REG_RD, 2'b11, ALU_SLL};
      OP_SLT:   {sel.reg_dst, sel.wr_reg_d_src, sel.alu_op} = {REG_RD, 1'b1, ALU_SLT};
      OP_SW:    {sel.alu_src_b, sel.ext_sel} = 2'b11;
      OP_LW:    {sel.reg_dst, sel.wr_reg_d_src, sel.db_data_src, sel.alu_src_b, sel.ext_sel} = {REG_RT, 4'b1111};
      OP_BEQ:   {sel.ext_sel, sel.alu_op, sel.pc_src} = {1'b1, ALU_SUB, zero ? PC_BR : PC_NEXT};
      OP_BNE:   {sel.ext_sel, sel.alu_op, sel.pc_src} = {1'b1, ALU_SUB, zero ? PC_NEXT : PC_BR};
      OP_BLTZ:  {sel.ext_sel, sel.alu_op, sel.pc_src} = {1'b1, ALU_SUB, sign ? PC_BR : PC_NEXT};
      OP_J:     sel.pc_src = PC_J;
      OP_JR:    sel.pc_src = PC_JR;
      OP_JAL:   {sel.reg_dst, sel.wr_reg_d_src, sel.pc_src} = {REG_RA, 1'b0, PC_J};
      default:  sel = '0;
    endcase
  end

  // Selects are meaningless in IF (opcode still belongs to the previous instruction).
  always_comb begin
    ctrl = '0;
    if (rst_n && state == S_IF) begin
      ctrl.ir_wre     = 1'b1;
      ctrl.ins_mem_rw = 1'b1;
    end else if (rst_n) begin
      ctrl         = sel;
      ctrl.pc_wre  = state inside {S_WB_AL, S_WB_L, S_EXE_BR} || (state == S_MEM && op_code == OP_SW) ||
                     (state == S_ID && op_code inside {OP_J, OP_JR, OP_JAL});
      ctrl.reg_wre = state inside {S_WB_AL, S_WB_L} || (state == S_ID && op_code == OP_JAL);
      ctrl.m_wr    = state == S_MEM && op_code == OP_SW;
      ctrl.m_rd    = state inside {S_MEM, S_WB_L} && op_code == OP_LW;
    end
  end

endmodule

// File: rtl/control_unit_fsm.sv
// control_unit_fsm: multicycle MIPS-subset controller sequencing IF/ID/EXE/MEM/WB.
module control_unit_fsm
  import control_unit_fsm_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 3
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic [OPW-1:0] opCode,
  input  logic           zero,
  input  logic           sign,
  output logic           PCWre,
  output logic           IRWre,
  output logic           InsMemRW,
  output logic           mRD,
  output logic           mWR,
  output logic           RegWre,
  output logic [1:0]     RegDst,
  output logic           WrRegDSrc,
  output logic           DBDataSrc,
  output logic           ALUSrcA,
  output logic           ALUSrcB,
  output logic           ExtSel,
  output logic [2:0]     ALUOp,
  output logic [1:0]     PCSrc,
  output logic [STW-1:0] state
);

  state_t cur;
  ctrl_t  ctrl;

  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) cur <= S_IF;
    else cur <= next_state(cur, opCode);

  control_unit_fsm_decoder u_dec (
    .rst_n   (Reset),
    .state   (cur),
    .op_code (opCode),
    .zero    (zero),
    .sign    (sign),
    .ctrl    (ctrl)
  );

  assign state = cur;
  assign {PCWre, IRWre, InsMemRW, mRD, mWR, RegWre, RegDst, WrRegDSrc, DBDataSrc,
          ALUSrcA, ALUSrcB, ExtSel, ALUOp, PCSrc} = ctrl;

endmodule

// File: tb/tb_control_unit_fsm.sv
// tb_control_unit_fsm: scoreboard bench walking every instruction class through the controller.
module tb_control_unit_fsm;

  localparam logic [2:0] T_IF = 3'b000, T_ID = 3'b001, T_EXE_AL = 3'b110, T_WB_AL = 3'b111;
  localparam logic [2:0] T_EXE_LS = 3'b010, T_MEM = 3'b011, T_WB_L = 3'b100, T_EXE_BR = 3'b101;
  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDIU = 6'b000010, AND_ = 6'b010000;
  localparam logic [5:0] ANDI = 6'b010001, ORI = 6'b010010, SLL = 6'b011000, SLT = 6'b100110;
  localparam logic [5:0] SW = 6'b110000, LW = 6'b110001, BEQ = 6'b110100, BNE = 6'b110101;
  localparam logic [5:0] BLTZ = 6'b110110, J = 6'b111000, JR = 6'b111001, JAL = 6'b111010;
  localparam logic [5:0] HALT = 6'b111111;

  logic       CLK = 1'b0, Reset = 1'b0, zero = 1'b0, sign = 1'b0;
  logic [5:0] opCode = HALT;
  logic       PCWre, IRWre, InsMemRW, mRD, mWR, RegWre, WrRegDSrc, DBDataSrc, ALUSrcA, ALUSrcB, ExtSel;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp, state;
  logic [17:0] obs;

  typedef struct packed {
    logic [2:0]  st;
    logic [17:0] ctl;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0, n_fail = 0;

  control_unit_fsm dut (
    .CLK(CLK), .Reset(Reset), .opCode(opCode), .zero(zero), .sign(sign),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .mRD(mRD), .mWR(mWR), .RegWre(RegWre),
    .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .PCSrc(PCSrc), .state(state)
  );

  assign obs = {PCWre, IRWre, InsMemRW, mRD, mWR, RegWre, RegDst, WrRegDSrc, DBDataSrc,
                ALUSrcA, ALUSrcB, ExtSel, ALUOp, PCSrc};

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (op %b, t=%0t)", tag, got, exp, opCode, $time);
    end
  endtask

  function automatic logic [17:0] model(logic [2:0] st, logic [5:0] op, logic z, logic s);
    logic pcw, rw, mw, mr, wsrc, db, a, b, ext;
    logic [1:0] rd, pcs;
    logic [2:0] alu;
    if (st == T_IF) return 18'b011 << 15;
    {rd, wsrc, db, a, b, ext, alu, pcs} = '0;
    case (op)
      ADD:   begin rd = 2'b10; wsrc = 1; end
      SUB:   begin rd = 2'b10; wsrc = 1; alu = 3'b001; end
      ADDIU: begin rd = 2'b01; wsrc = 1; b = 1; ext = 1; end
      AND_:  begin rd = 2'b10; wsrc = 1; alu = 3'b100; end
      ANDI:  begin rd = 2'b01; wsrc = 1; b = 1; alu = 3'b100; end
      ORI:   begin rd = 2'b01; wsrc = 1; b = 1; alu = 3'b011; end
      SLL:   begin rd = 2'b10; wsrc = 1; a = 1; alu = 3'b010; end
      SLT:   begin rd = 2'b10; wsrc = 1; alu = 3'b110; end
      SW:    begin b = 1; ext = 1; end
      LW:    begin rd = 2'b01; wsrc = 1; db = 1; b = 1; ext = 1; end
      BEQ:   begin ext = 1; alu = 3'b001; pcs = z ? 2'b01 : 2'b00; end
      BNE:   begin ext = 1; alu = 3'b001; pcs = z ? 2'b00 : 2'b01; end
      BLTZ:  begin ext = 1; alu = 3'b001; pcs = s ? 2'b01 : 2'b00; end
      J:     pcs = 2'b11;
      JR:    pcs = 2'b10;
      JAL:   pcs = 2'b11;
      default: ;
    endcase
    pcw = st == T_WB_AL || st == T_WB_L || st == T_EXE_BR || (st == T_MEM && op == SW) ||
          (st == T_ID && (op == J || op == JR || op == JAL));
    rw  = st == T_WB_AL || st == T_WB_L || (st == T_ID && op == JAL);
    mw  = st == T_MEM && op == SW;
    mr  = (st == T_MEM || st == T_WB_L) && op == LW;
    return {pcw, 2'b00, mr, mw, rw, rd, wsrc, db, a, b, ext, alu, pcs};
  endfunction

  always @(negedge CLK)
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("state", {29'd0, state}, {29'd0, e.st});
      check("ctrl", {14'd0, obs}, {14'd0, e.ctl});
    end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [2:0] st);
    sb.push_back({st, model(st, opCode, zero, sign)});
  endtask

  task automatic run(input logic [5:0] op, input logic z, input logic s);
    logic [2:0] path[$];
    push(T_IF);
    tick();
    opCode = op; zero = z; sign = s;
    path.push_back(T_ID);
    case (op)
      ADD, SUB, ADDIU, AND_, ANDI, ORI, SLL, SLT: begin path.push_back(T_EXE_AL); path.push_back(T_WB_AL); end
      LW: begin path.push_back(T_EXE_LS); path.push_back(T_MEM); path.push_back(T_WB_L); end
      SW: begin path.push_back(T_EXE_LS); path.push_back(T_MEM); end
      BEQ, BNE, BLTZ: path.push_back(T_EXE_BR);
      default: ;
    endcase
    foreach (path[i]) begin
      push(path[i]);
      tick();
    end
  endtask

  task automatic park(input logic [5:0] op, input int cycles);
    push(T_IF);
    tick();
    opCode = op;
    repeat (cycles) begin
      push(T_ID);
      tick();
    end
  endtask

  task automatic pulse_reset();
    Reset = 1'b0;
    #1;
    check("rst_pulse_state", {29'd0, state}, 32'd0);
    check("rst_pulse_ctrl", {14'd0, obs}, 32'd0);
    tick();
    Reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) begin
      @(negedge CLK);
      check("rst_state", {29'd0, state}, 32'd0);
      check("rst_ctrl", {14'd0, obs}, 32'd0);
    end
    tick();
    Reset = 1'b1;
    run(ADD, 1'b0, 1'b0);
    run(LW, 1'b1, 1'b1);
    run(SW, 1'b0, 1'b1);
    run(BEQ, 1'b1, 1'b0);
    run(BEQ, 1'b0, 1'b0);
    run(BNE, 1'b0, 1'b0);
    run(BNE, 1'b1, 1'b0);
    run(BLTZ, 1'b0, 1'b1);
    run(BLTZ, 1'b1, 1'b0);
    run(SUB, 1'b1, 1'b0);
    run(ADDIU, 1'b0, 1'b1);
    run(AND_, 1'b0, 1'b0);
    run(ANDI, 1'b1, 1'b1);
    run(ORI, 1'b0, 1'b0);
    run(SLL, 1'b0, 1'b0);
    run(SLT, 1'b0, 1'b1);
    run(J, 1'b0, 1'b0);
    run(JR, 1'b0, 1'b0);
    run(JAL, 1'b0, 1'b0);
    run(ADD, 1'b1, 1'b1);
    // sw aborted by reset while its write strobe is high
    push(T_IF); tick();
    opCode = SW;
    push(T_ID); tick();
    push(T_EXE_LS); tick();
    push(T_MEM);
    @(negedge CLK);
    #1;
    check("mid_mwr_high", {31'd0, mWR}, 32'd1);
    Reset = 1'b0;
    #1;
    check("abort_mwr", {31'd0, mWR}, 32'd0);
    check("abort_pcwre", {31'd0, PCWre}, 32'd0);
    check("abort_state", {29'd0, state}, 32'd0);
    tick();
    Reset = 1'b1;
    run(JAL, 1'b1, 1'b1);
    park(HALT, 6);
    pulse_reset();
    park(6'b101010, 4);
    pulse_reset();
    run(LW, 1'b0, 1'b0);
    @(negedge CLK);
    #1;
    check("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
